// File: rtl/key_gesture_decoder.sv
// -----------------------------------------------------------------------------
// key_gesture_decoder
//
// Turns the debounced key interface into gesture pulses: single click, double
// click, long press and auto-repeat ticks while the key stays held after a
// long press. Runs on the same clock as the key filter that feeds it.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   key_status    in   debounced level, 1 = released, 0 = pressed
//   key_event     in   one-cycle pulse, high in the cycle key_status changes
//   single_click  out  one-cycle pulse
//   double_click  out  one-cycle pulse
//   long_press    out  one-cycle pulse when the hold reaches LONG_CYC
//   repeat_tick   out  one-cycle pulse every REPEAT_CYC cycles while in LONG
//   busy          out  level, high whenever the FSM is not in IDLE
//   dbg_state_o   out  current FSM state, for observation only
//
// Input protocol: key_event is a qualifier, not a handshake. There is no
// backpressure; an event is consumed in the cycle it is presented. An event
// the current state does not expect is dropped without touching the state
// or the counter.
// -----------------------------------------------------------------------------
module key_gesture_decoder #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned DCLICK_CYC = 15_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_status,
    input  logic       key_event,
    output logic       single_click,
    output logic       double_click,
    output logic       long_press,
    output logic       repeat_tick,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRESS1 = 3'd1;
    localparam logic [2:0] WAIT2  = 3'd2;
    localparam logic [2:0] PRESS2 = 3'd3;
    localparam logic [2:0] LONG   = 3'd4;

    // Last count value of each interval; a compare hit means the interval
    // has fully elapsed on this clock edge.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             busy_q, busy_d;

    logic press_ev;
    logic release_ev;

    assign press_ev   = key_event & ~key_status;
    assign release_ev = key_event &  key_status;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press_ev) begin
                    state_d = PRESS1;
                end
            end
            PRESS1: begin
                // Release takes priority over the long-press timeout.
                if (release_ev) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT2: begin
                // A second press in the final window cycle still counts.
                if (press_ev) begin
                    state_d = PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    single_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESS2: begin
                // No timeout here: any hold length ends as a double click.
                cnt_d = '0;
                if (release_ev) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            LONG: begin
                // Release ends the gesture silently and masks a coincident tick.
                if (release_ev) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Unreachable encodings recover to IDLE with all pulses low.
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            busy_q   <= busy_d;
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign long_press   = long_q;
    assign repeat_tick  = repeat_q;
    assign busy         = busy_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_key_gesture_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_gesture_decoder
//
// Directed bench for key_gesture_decoder with LONG_CYC=20, DCLICK_CYC=10,
// REPEAT_CYC=5. Inputs change 1 ns after a rising edge; outputs are checked
// at the same point, i.e. they show what the previous edge registered.
// Cycle offsets in the comments are relative to the cycle the first key
// event of each gesture is presented in (T).
// Output vector order: {single_click, double_click, long_press, repeat_tick, busy}.
// -----------------------------------------------------------------------------
module tb_key_gesture_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_status = 1'b1;
    logic       key_event = 1'b0;
    logic       single_click;
    logic       double_click;
    logic       long_press;
    logic       repeat_tick;
    logic       busy;
    logic [2:0] dbg_state_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    key_gesture_decoder #(
        .LONG_CYC  (20),
        .DCLICK_CYC(10),
        .REPEAT_CYC(5),
        .CNT_W     (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_status  (key_status),
        .key_event   (key_event),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_tick (repeat_tick),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        key_status = 1'b0;
        key_event  = 1'b1;
        tick();
        key_event  = 1'b0;
    endtask

    task automatic release_key();
        key_status = 1'b1;
        key_event  = 1'b1;
        tick();
        key_event  = 1'b0;
    endtask

    // ---------------- checkers ----------------
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {single_click, double_click, long_press, repeat_tick, busy};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        vectors++;
        assert (dbg_state_o === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, dbg_state_o, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset, then 50 idle cycles with everything low.
        idle(3);
        chk("reset_outs", 5'b00000);
        chk_state("reset_state", 3'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            chk("idle_after_reset", 5'b00000);
            tick();
        end

        // Single click: press at T, release at T+5, pulse at T+16.
        press();                                   // now in T+1
        for (int c = 1; c <= 4; c++) begin
            chk("single_press_hold", 5'b00001);
            tick();
        end
        release_key();                             // now in T+6
        for (int c = 6; c <= 22; c++) begin
            if (c == 16)     chk("single_pulse", 5'b10000);
            else if (c < 16) chk("single_wait", 5'b00001);
            else             chk("single_after", 5'b00000);
            tick();
        end

        // Double click: press T, release T+5, press T+10, release T+30.
        press();                                   // T+1
        for (int c = 1; c <= 4; c++) begin
            chk("dbl_press1", 5'b00001);
            tick();
        end
        release_key();                             // T+6
        for (int c = 6; c <= 9; c++) begin
            chk("dbl_wait2", 5'b00001);
            tick();
        end
        press();                                   // T+11
        chk_state("dbl_in_press2", 3'd3);
        for (int c = 11; c <= 29; c++) begin
            chk("dbl_press2_hold", 5'b00001);
            tick();
        end
        release_key();                             // T+31
        for (int c = 31; c <= 45; c++) begin
            if (c == 31) chk("dbl_pulse", 5'b01000);
            else         chk("dbl_after", 5'b00000);
            tick();
        end

        // Long press: press T, long_press T+21, ticks T+26/31/36, release T+38.
        press();                                   // T+1
        for (int c = 1; c <= 37; c++) begin
            chk("long_hold", {1'b0, 1'b0, c == 21, (c == 26) || (c == 31) || (c == 36), 1'b1});
            tick();
        end
        release_key();                             // T+39
        for (int c = 39; c <= 55; c++) begin
            chk("long_after_release", 5'b00000);
            tick();
        end

        // Boundary: release exactly when cnt==19 in PRESS1 (cycle T+20).
        press();                                   // T+1
        for (int c = 1; c <= 19; c++) begin
            chk("bnd_long_hold", 5'b00001);
            tick();
        end
        release_key();                             // T+21
        chk_state("bnd_long_to_wait2", 3'd2);
        for (int c = 21; c <= 36; c++) begin
            if (c == 31)     chk("bnd_long_single", 5'b10000);
            else if (c < 31) chk("bnd_long_wait", 5'b00001);
            else             chk("bnd_long_after", 5'b00000);
            tick();
        end

        // Boundary: second press exactly when cnt==9 in WAIT2.
        // Release at R; cnt==9 during R+10.
        press();
        idle(2);
        release_key();                             // R+1
        for (int c = 1; c <= 9; c++) begin
            chk("bnd_dbl_wait", 5'b00001);
            tick();
        end
        press();                                   // R+11
        for (int c = 11; c <= 14; c++) begin
            chk("bnd_dbl_press2", 5'b00001);
            tick();
        end
        release_key();                             // R+16
        for (int c = 16; c <= 30; c++) begin
            if (c == 16) chk("bnd_dbl_pulse", 5'b01000);
            else         chk("bnd_dbl_after", 5'b00000);
            tick();
        end

        // Reset in the middle of WAIT2, then a stray release event.
        press();
        idle(2);
        release_key();
        idle(3);
        chk("rst_wait2_pre", 5'b00001);
        rst_n = 1'b0;
        #1;
        chk("rst_wait2_async", 5'b00000);
        chk_state("rst_wait2_state", 3'd0);
        idle(2);
        rst_n = 1'b1;
        tick();
        release_key();
        for (int c = 0; c < 15; c++) begin
            chk("rst_wait2_stray", 5'b00000);
            tick();
        end
        chk_state("rst_wait2_idle", 3'd0);

        // Reset in the middle of LONG, then a stray release event.
        press();
        idle(25);
        chk_state("rst_long_pre", 3'd4);
        rst_n = 1'b0;
        #1;
        chk("rst_long_async", 5'b00000);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("rst_long_held_level", 5'b00000);
        release_key();
        for (int c = 0; c < 15; c++) begin
            chk("rst_long_stray", 5'b00000);
            tick();
        end
        chk_state("rst_long_idle", 3'd0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
